// File: rtl/bf2i_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bf2i_pkg
//  Purpose  : Shared defaults, sample typedefs and butterfly index helpers for
//             the parallel radix-2 butterfly stage (BF2I).
//  Contents : BF2I_WIDTH / BF2I_DEPTH / BF2I_OFFSET default parameters,
//             bf2i_in_t / bf2i_out_t sample types at the default width,
//             bf2i_is_top()  - index sits in the upper half of its group,
//             bf2i_partner() - index of the butterfly partner.
//  Revision : 1.0 - initial release
// ============================================================================
package bf2i_pkg;

  localparam int BF2I_WIDTH  = 9;
  localparam int BF2I_DEPTH  = 16;
  localparam int BF2I_OFFSET = 1;

  typedef logic signed [BF2I_WIDTH-1:0] bf2i_in_t;
  typedef logic signed [BF2I_WIDTH:0]   bf2i_out_t;

  // Groups are 2*offset wide; the first half of each group holds the "top"
  // (sum) positions, the second half the "bottom" (difference) positions.
  function automatic bit bf2i_is_top(input int idx, input int offset);
    return ((idx / offset) % 2) == 0;
  endfunction

  function automatic int bf2i_partner(input int idx, input int offset);
    return bf2i_is_top(idx, offset) ? (idx + offset) : (idx - offset);
  endfunction

endpackage : bf2i_pkg
`default_nettype wire

// File: rtl/bf2i_pair.sv
`default_nettype none
// ============================================================================
//  Module   : bf2i_pair
//  Purpose  : Combinational single complex radix-2 butterfly. Both operands
//             are sign-extended by one bit so sum and difference never wrap.
//  Ports    : a_R, a_Q  - top operand (WIDTH bits, signed)
//             b_R, b_Q  - bottom operand (WIDTH bits, signed)
//             sum_R, sum_Q   - a + b (WIDTH+1 bits, signed)
//             diff_R, diff_Q - a - b (WIDTH+1 bits, signed)
//  Revision : 1.0 - initial release
// ============================================================================
module bf2i_pair
  import bf2i_pkg::*;
#(
  parameter int WIDTH = BF2I_WIDTH
) (
  input  logic signed [WIDTH-1:0] a_R,
  input  logic signed [WIDTH-1:0] a_Q,
  input  logic signed [WIDTH-1:0] b_R,
  input  logic signed [WIDTH-1:0] b_Q,
  output logic signed [WIDTH:0]   sum_R,
  output logic signed [WIDTH:0]   sum_Q,
  output logic signed [WIDTH:0]   diff_R,
  output logic signed [WIDTH:0]   diff_Q
);

  logic signed [WIDTH:0] w_a_R_ext;
  logic signed [WIDTH:0] w_a_Q_ext;
  logic signed [WIDTH:0] w_b_R_ext;
  logic signed [WIDTH:0] w_b_Q_ext;

  assign w_a_R_ext = {a_R[WIDTH-1], a_R};
  assign w_a_Q_ext = {a_Q[WIDTH-1], a_Q};
  assign w_b_R_ext = {b_R[WIDTH-1], b_R};
  assign w_b_Q_ext = {b_Q[WIDTH-1], b_Q};

  assign sum_R  = w_a_R_ext + w_b_R_ext;
  assign sum_Q  = w_a_Q_ext + w_b_Q_ext;
  assign diff_R = w_a_R_ext - w_b_R_ext;
  assign diff_Q = w_a_Q_ext - w_b_Q_ext;

endmodule : bf2i_pair
`default_nettype wire

// File: rtl/bf2i_1bundle.sv
`default_nettype none
// ============================================================================
//  Module   : bf2i_1bundle
//  Purpose  : Parallel radix-2 butterfly stage. One bundle of DEPTH complex
//             samples per cycle; elements OFFSET apart are paired, the top
//             position receives the sum and the bottom the difference.
//             Results are registered (1 cycle latency) and only update when
//             en is high.
//  Ports    : clk        - clock, rising edge
//             rst_n      - asynchronous active-low reset (clears outputs)
//             en         - output register update enable
//             din_R/Q    - DEPTH x WIDTH signed input samples
//             dout_R/Q   - DEPTH x (WIDTH+1) signed registered results
//             dout_valid - (only with BF2I_DOUT_VALID_EN) en delayed 1 cycle
//  Options  : BF2I_DOUT_VALID_EN - adds the dout_valid output register
//  Params   : DEPTH must be a multiple of 2*OFFSET, OFFSET >= 1.
//  Revision : 1.0 - initial release
// ============================================================================
module bf2i_1bundle
  import bf2i_pkg::*;
#(
  parameter int WIDTH  = BF2I_WIDTH,
  parameter int DEPTH  = BF2I_DEPTH,
  parameter int OFFSET = BF2I_OFFSET
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] din_R  [DEPTH-1:0],
  input  logic signed [WIDTH-1:0] din_Q  [DEPTH-1:0],
  output logic signed [WIDTH:0]   dout_R [DEPTH-1:0],
  output logic signed [WIDTH:0]   dout_Q [DEPTH-1:0]
`ifdef BF2I_DOUT_VALID_EN
  ,
  output logic                    dout_valid
`endif
);

  // Butterfly results, indexed by output position.
  logic signed [WIDTH:0] w_bf_R [DEPTH-1:0];
  logic signed [WIDTH:0] w_bf_Q [DEPTH-1:0];

  logic signed [WIDTH:0] dout_R_d [DEPTH-1:0];
  logic signed [WIDTH:0] dout_Q_d [DEPTH-1:0];
  logic signed [WIDTH:0] dout_R_q [DEPTH-1:0];
  logic signed [WIDTH:0] dout_Q_q [DEPTH-1:0];

  // Butterfly p lives in group p/OFFSET at lane p%OFFSET; its top index is
  // the group base plus the lane, its bottom index sits OFFSET further on.
  for (genvar p = 0; p < DEPTH / 2; p++) begin : g_bfly
    localparam int T = (p / OFFSET) * 2 * OFFSET + (p % OFFSET);
    localparam int U = bf2i_partner(T, OFFSET);

    bf2i_pair #(
      .WIDTH (WIDTH)
    ) u_pair (
      .a_R    (din_R[T]),
      .a_Q    (din_Q[T]),
      .b_R    (din_R[U]),
      .b_Q    (din_Q[U]),
      .sum_R  (w_bf_R[T]),
      .sum_Q  (w_bf_Q[T]),
      .diff_R (w_bf_R[U]),
      .diff_Q (w_bf_Q[U])
    );
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      dout_R_d[i] = dout_R_q[i];
      dout_Q_d[i] = dout_Q_q[i];
      if (en) begin
        dout_R_d[i] = w_bf_R[i];
        dout_Q_d[i] = w_bf_Q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        dout_R_q[i] <= '0;
        dout_Q_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        dout_R_q[i] <= dout_R_d[i];
        dout_Q_q[i] <= dout_Q_d[i];
      end
    end
  end

  assign dout_R = dout_R_q;
  assign dout_Q = dout_Q_q;

`ifdef BF2I_DOUT_VALID_EN
  logic dout_valid_d;
  logic dout_valid_q;

  // Loaded every clock, so it marks exactly the cycles after an update.
  always_comb begin
    dout_valid_d = en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout_valid = dout_valid_q;
`endif

endmodule : bf2i_1bundle
`default_nettype wire

// File: tb/tb_bf2i_1bundle.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bf2i_1bundle
//  Purpose  : Self-checking bench for bf2i_1bundle. Two instances share the
//             inputs: OFFSET=1 and OFFSET=4 (both DEPTH=16, WIDTH=9).
//             Stimulus pushes the expected bundle per driven cycle; a monitor
//             pops and compares after every clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bf2i_1bundle;

  localparam int W = 9;
  localparam int D = 16;

  typedef logic signed [W-1:0] in_arr_t [D-1:0];
  typedef logic [D-1:0][W:0]   out_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic signed [W-1:0] din_R [D-1:0];
  logic signed [W-1:0] din_Q [D-1:0];
  logic signed [W:0]   dout_R1 [D-1:0];
  logic signed [W:0]   dout_Q1 [D-1:0];
  logic signed [W:0]   dout_R4 [D-1:0];
  logic signed [W:0]   dout_Q4 [D-1:0];
`ifdef BF2I_DOUT_VALID_EN
  logic dout_valid1;
  logic dout_valid4;
  bit   q_v [$];
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  out_vec_t q_r1 [$];
  out_vec_t q_q1 [$];
  out_vec_t q_r4 [$];
  out_vec_t q_q4 [$];

  // Model state: what each instance's output registers should hold.
  out_vec_t m_r1, m_q1, m_r4, m_q4;

  always #5 clk = ~clk;

  bf2i_1bundle #(.WIDTH(W), .DEPTH(D), .OFFSET(1)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .din_R  (din_R),
    .din_Q  (din_Q),
    .dout_R (dout_R1),
    .dout_Q (dout_Q1)
`ifdef BF2I_DOUT_VALID_EN
    ,
    .dout_valid (dout_valid1)
`endif
  );

  bf2i_1bundle #(.WIDTH(W), .DEPTH(D), .OFFSET(4)) u_dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .din_R  (din_R),
    .din_Q  (din_Q),
    .dout_R (dout_R4),
    .dout_Q (dout_Q4)
`ifdef BF2I_DOUT_VALID_EN
    ,
    .dout_valid (dout_valid4)
`endif
  );

  // Reference butterfly written from the group/partner definition.
  function automatic out_vec_t bfly(input in_arr_t d, input int off);
    out_vec_t r;
    logic signed [W:0] a, b;
    for (int i = 0; i < D; i++) begin
      if (((i / off) % 2) == 0) begin
        a = d[i]; b = d[i + off];
        r[i] = a + b;
      end else begin
        a = d[i - off]; b = d[i];
        r[i] = a - b;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic signed [W:0] act,
                     input logic signed [W:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cmp_vec(input string name, input logic signed [W:0] act [D-1:0],
                         input out_vec_t exp);
    for (int i = 0; i < D; i++) begin
      n_cmp++;
      if (act[i] !== $signed(exp[i])) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %0d want %0d", name, i, act[i], $signed(exp[i]));
      end
    end
  endtask

  task automatic flush_model();
    m_r1 = '0; m_q1 = '0; m_r4 = '0; m_q4 = '0;
    q_r1.delete(); q_q1.delete(); q_r4.delete(); q_q4.delete();
`ifdef BF2I_DOUT_VALID_EN
    q_v.delete();
`endif
  endtask

  // Drive one cycle and push the expected post-edge register contents.
  task automatic step(input logic e, input in_arr_t r, input in_arr_t q);
    @(negedge clk);
    en    = e;
    din_R = r;
    din_Q = q;
    if (e) begin
      m_r1 = bfly(r, 1); m_q1 = bfly(q, 1);
      m_r4 = bfly(r, 4); m_q4 = bfly(q, 4);
    end
    q_r1.push_back(m_r1); q_q1.push_back(m_q1);
    q_r4.push_back(m_r4); q_q4.push_back(m_q4);
`ifdef BF2I_DOUT_VALID_EN
    q_v.push_back(e);
`endif
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected bundle per clock edge taken out of reset.
  initial begin
    out_vec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q_r1.size() > 0) begin
        e = q_r1.pop_front(); cmp_vec("dut1.dout_R", dout_R1, e);
        e = q_q1.pop_front(); cmp_vec("dut1.dout_Q", dout_Q1, e);
        e = q_r4.pop_front(); cmp_vec("dut4.dout_R", dout_R4, e);
        e = q_q4.pop_front(); cmp_vec("dut4.dout_Q", dout_Q4, e);
`ifdef BF2I_DOUT_VALID_EN
        begin
          bit v;
          v = q_v.pop_front();
          n_cmp++;
          if (dout_valid1 !== v || dout_valid4 !== v) begin
            n_fail++;
            $display("FAIL dout_valid: got %b/%b want %b", dout_valid1, dout_valid4, v);
          end
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_arr_t r, q;

    // ---------------- reset with nonzero inputs ----------------
    flush_model();
    for (int i = 0; i < D; i++) begin
      din_R[i] = W'(i + 1);
      din_Q[i] = W'(-i - 1);
    end
    en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < D; i++) begin
      chk($sformatf("reset.dout_R1[%0d]", i), dout_R1[i], 0);
      chk($sformatf("reset.dout_Q4[%0d]", i), dout_Q4[i], 0);
    end
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;

    // ---------------- enable gating ----------------
    for (int i = 0; i < D; i++) begin r[i] = W'(10 + i); q[i] = W'(20 + i); end
    step(1'b0, r, q);
    after_edge();
    chk("gate.dout_R1[0]", dout_R1[0], 0);
    chk("gate.dout_Q1[1]", dout_Q1[1], 0);

    // ---------------- basic OFFSET=1 ----------------
    for (int i = 0; i < D; i++) begin r[i] = W'(3 * i); q[i] = W'(2 * (15 - i)); end
    step(1'b1, r, q);
    after_edge();
    chk("basic.dout_R1[0]", dout_R1[0], 3);
    chk("basic.dout_R1[1]", dout_R1[1], -3);
    chk("basic.dout_Q1[0]", dout_Q1[0], 58);
    chk("basic.dout_Q1[1]", dout_Q1[1], 2);

    // ---------------- signed boundaries ----------------
    for (int i = 0; i < D; i++) begin
      r[i] = '0;
      q[i] = (i % 2 == 0) ? W'(10 * i) : W'(-10 * i);
    end
    r[0] = 9'sd255;  r[1] = 9'sd255;
    r[2] = -9'sd256; r[3] = -9'sd256;
    r[4] = 9'sd255;  r[5] = -9'sd256;
    r[6] = -9'sd256; r[7] = 9'sd255;
    step(1'b1, r, q);
    after_edge();
    chk("bound.dout_R1[0]", dout_R1[0], 510);
    chk("bound.dout_R1[1]", dout_R1[1], 0);
    chk("bound.dout_R1[2]", dout_R1[2], -512);
    chk("bound.dout_R1[3]", dout_R1[3], 0);
    chk("bound.dout_R1[4]", dout_R1[4], -1);
    chk("bound.dout_R1[5]", dout_R1[5], 511);
    chk("bound.dout_R1[6]", dout_R1[6], -1);
    chk("bound.dout_R1[7]", dout_R1[7], -511);
    chk("bound.dout_Q1[0]", dout_Q1[0], -10);
    chk("bound.dout_Q1[1]", dout_Q1[1], 10);

    // ---------------- hold with en=0 ----------------
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < D; i++) begin r[i] = W'(i * 7 + c); q[i] = W'(-i * 5 - c); end
      step(1'b0, r, q);
    end
    after_edge();
    chk("hold.dout_R1[5]", dout_R1[5], 511);
    chk("hold.dout_Q1[0]", dout_Q1[0], -10);

    // ---------------- OFFSET=4 instance ----------------
    for (int i = 0; i < D; i++) begin r[i] = W'(i); q[i] = W'(-i); end
    step(1'b1, r, q);
    after_edge();
    chk("off4.dout_R4[0]", dout_R4[0], 4);
    chk("off4.dout_R4[3]", dout_R4[3], 10);
    chk("off4.dout_R4[4]", dout_R4[4], -4);
    chk("off4.dout_R4[7]", dout_R4[7], -4);
    chk("off4.dout_R4[8]", dout_R4[8], 20);
    chk("off4.dout_R4[11]", dout_R4[11], 26);
    chk("off4.dout_R4[12]", dout_R4[12], -4);
    chk("off4.dout_Q4[0]", dout_Q4[0], -4);

    // ---------------- a few random bundles through the model ----------------
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < D; i++) begin
        r[i] = W'($urandom_range(0, 511));
        q[i] = W'($urandom_range(0, 511));
      end
      step(($urandom_range(0, 3) != 0), r, q);
    end

    // ---------------- asynchronous reset mid-run ----------------
    for (int i = 0; i < D; i++) begin r[i] = W'(100 + i); q[i] = W'(-50 - i); end
    step(1'b1, r, q);
    after_edge();
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < D; i++) begin din_R[i] = W'(30 - i); din_Q[i] = W'(i); end
    #2;
    rst_n = 1'b0;
    flush_model();
    #1;
    for (int i = 0; i < D; i++) begin
      chk($sformatf("async.dout_R1[%0d]", i), dout_R1[i], 0);
      chk($sformatf("async.dout_R4[%0d]", i), dout_R4[i], 0);
    end
    after_edge();
    chk("async_hold.dout_Q1[0]", dout_Q1[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;

    // first bundle after release
    for (int i = 0; i < D; i++) begin r[i] = W'(i); q[i] = W'(i); end
    step(1'b1, r, q);
    after_edge();
    chk("release.dout_R1[0]", dout_R1[0], 1);
    chk("release.dout_R1[1]", dout_R1[1], -1);

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && q_r1.size() != 0; i++) @(posedge clk);
    #2;
    n_cmp++;
    if (q_r1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q_r1.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_bf2i_1bundle
`default_nettype wire
